// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding decode.
// Owns the fetch PC, runs a request/addr_ok/data_ok handshake with the instruction SRAM,
// holds one fetched word until decode takes it, and honours writeback flush/redirect.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   id_allowin_in            decode can accept this cycle
//   if_valid_out             held instruction is valid for decode
//   id_nextPC_in             next fetch PC chosen by decode
//   wb_ClrStpJmp_in          writeback flush + redirect
//   wb_cp0_res_in            redirect target on flush
//   inst_req/inst_addr       SRAM request and address
//   inst_addr_ok             request accepted
//   inst_data_ok/inst_rdata  read data returned
//   if_PC_out/NPC/NNPC       PC, PC+4, PC+8 of the held instruction
//   if_Instruct_out          held instruction word (0 when not valid)
//   if_NPC_fast_wire         combinational PC+4 for decode's sequential path
//   if_exception_out         misaligned-fetch exception
//   if_ExcCode_out           exception code
//   if_error_VAddr_out       faulting fetch address
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [4:0]  ADEL_CODE = 5'h04
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_allowin_in,
  output logic        if_valid_out,
  input  logic [31:0] id_nextPC_in,
  input  logic        wb_ClrStpJmp_in,
  input  logic [31:0] wb_cp0_res_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_Instruct_out,
  output logic [31:0] if_NPC_fast_wire,
  output logic        if_exception_out,
  output logic [4:0]  if_ExcCode_out,
  output logic [31:0] if_error_VAddr_out
);

  localparam logic [1:0] StReq     = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StValid   = 2'd2;
  localparam logic [1:0] StDiscard = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        exc_q, exc_d;

  logic pc_aligned;
  logic in_valid;
  logic req_outstanding;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign in_valid   = (state_q == StValid);

  // A response is still owed by the SRAM after this edge: either already in flight and not
  // returning now, or being accepted right now.
  assign req_outstanding =
      (((state_q == StWait) || (state_q == StDiscard)) && !inst_data_ok) ||
      ((state_q == StReq) && pc_aligned && inst_addr_ok);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    exc_d      = exc_q;
    inst_req   = 1'b0;

    case (state_q)
      StReq: begin
        if (pc_aligned) begin
          inst_req = 1'b1;
          if (inst_addr_ok) state_d = StWait;
        end else begin
          // Misaligned fetch never reaches the SRAM; present it as an exception slot.
          exc_d      = 1'b1;
          inst_buf_d = 32'h0;
          state_d    = StValid;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          inst_buf_d = inst_rdata;
          exc_d      = 1'b0;
          state_d    = StValid;
        end
      end
      StValid: begin
        if (id_allowin_in) begin
          pc_d    = id_nextPC_in;
          state_d = StReq;
        end
      end
      StDiscard: begin
        if (inst_data_ok) state_d = StReq;
      end
      default: state_d = StReq;
    endcase

    // Flush overrides everything; a stale response still owed must be swallowed first.
    if (wb_ClrStpJmp_in) begin
      pc_d    = wb_cp0_res_in;
      state_d = req_outstanding ? StDiscard : StReq;
    end

    if (!rst_n) inst_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      inst_buf_q <= 32'h0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      exc_q      <= exc_d;
    end
  end

  assign inst_addr          = pc_q;
  assign if_valid_out       = rst_n && in_valid && !wb_ClrStpJmp_in;
  assign if_PC_out          = pc_q;
  assign if_NPC_out         = pc_q + 32'd4;
  assign if_NNPC_out        = pc_q + 32'd8;
  assign if_NPC_fast_wire   = pc_q + 32'd4;
  assign if_Instruct_out    = in_valid ? inst_buf_q : 32'h0;
  assign if_exception_out   = exc_q && in_valid;
  assign if_ExcCode_out     = if_exception_out ? ADEL_CODE : 5'h0;
  assign if_error_VAddr_out = if_exception_out ? pc_q : 32'h0;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] ResetPc = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_allowin_in;
  logic        if_valid_out;
  logic [31:0] id_nextPC_in;
  logic        wb_ClrStpJmp_in;
  logic [31:0] wb_cp0_res_in;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out, if_NPC_fast_wire;
  logic        if_exception_out;
  logic [4:0]  if_ExcCode_out;
  logic [31:0] if_error_VAddr_out;

  int errors = 0;
  int checks = 0;

  if_fetch_stage #(
    .RESET_PC (ResetPc),
    .ADEL_CODE(5'h04)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_allowin_in     (id_allowin_in),
    .if_valid_out      (if_valid_out),
    .id_nextPC_in      (id_nextPC_in),
    .wb_ClrStpJmp_in   (wb_ClrStpJmp_in),
    .wb_cp0_res_in     (wb_cp0_res_in),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_addr_ok      (inst_addr_ok),
    .inst_data_ok      (inst_data_ok),
    .inst_rdata        (inst_rdata),
    .if_PC_out         (if_PC_out),
    .if_NPC_out        (if_NPC_out),
    .if_NNPC_out       (if_NNPC_out),
    .if_Instruct_out   (if_Instruct_out),
    .if_NPC_fast_wire  (if_NPC_fast_wire),
    .if_exception_out  (if_exception_out),
    .if_ExcCode_out    (if_ExcCode_out),
    .if_error_VAddr_out(if_error_VAddr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: which PC is being fetched, whether a live or a stale
  // response is owed by the SRAM, and what instruction (if any) sits ready for decode.
  logic [31:0] m_pc;
  logic        m_live, m_stale, m_held, m_exc, m_req, m_show_exc;
  logic [31:0] m_data;
  logic [31:0] hand_pc[$];
  logic [31:0] hand_inst[$];
  logic        saw_stale = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc    = ResetPc;
      m_live  = 1'b0;
      m_stale = 1'b0;
      m_held  = 1'b0;
      m_exc   = 1'b0;
      m_data  = 32'h0;
    end else begin
      m_req      = !m_held && !m_live && !m_stale && (m_pc[1:0] == 2'b00);
      m_show_exc = m_held && m_exc;
      chk("pc", if_PC_out, m_pc);
      chk("npc", if_NPC_out, m_pc + 32'd4);
      chk("nnpc", if_NNPC_out, m_pc + 32'd8);
      chk("fast_npc", if_NPC_fast_wire, m_pc + 32'd4);
      chk("inst_req", {31'b0, inst_req}, {31'b0, m_req});
      if (m_req) chk("inst_addr", inst_addr, m_pc);
      chk("valid", {31'b0, if_valid_out}, {31'b0, m_held && !wb_ClrStpJmp_in});
      chk("instruct", if_Instruct_out, m_held ? m_data : 32'h0);
      chk("exception", {31'b0, if_exception_out}, {31'b0, m_show_exc});
      chk("exccode", {27'b0, if_ExcCode_out}, m_show_exc ? 32'h4 : 32'h0);
      chk("vaddr", if_error_VAddr_out, m_show_exc ? m_pc : 32'h0);
      if (if_Instruct_out == 32'hDEADBEEF) saw_stale = 1'b1;

      if (wb_ClrStpJmp_in) begin
        m_stale = ((m_live || m_stale) && !inst_data_ok) || (m_req && inst_addr_ok);
        m_live  = 1'b0;
        m_held  = 1'b0;
        m_pc    = wb_cp0_res_in;
      end else if (m_held) begin
        if (id_allowin_in) begin
          hand_pc.push_back(m_pc);
          hand_inst.push_back(m_data);
          m_held = 1'b0;
          m_pc   = id_nextPC_in;
        end
      end else if (m_stale) begin
        if (inst_data_ok) m_stale = 1'b0;
      end else if (m_live) begin
        if (inst_data_ok) begin
          m_live = 1'b0;
          m_held = 1'b1;
          m_data = inst_rdata;
          m_exc  = 1'b0;
        end
      end else if (m_req) begin
        if (inst_addr_ok) m_live = 1'b1;
      end else begin
        m_held = 1'b1;
        m_data = 32'h0;
        m_exc  = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    while (!inst_req && n < 20) begin
      cyc();
      n++;
    end
    chk("req_seen", {31'b0, inst_req}, 32'h1);
    chk("req_addr", inst_addr, exp_addr);
  endtask

  // Accept the pending request, return data in the first wait cycle.
  task automatic quick_fetch(input logic [31:0] data);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = data;
    cyc();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  task automatic handoff(input logic [31:0] next_pc);
    int n = 0;
    while (!if_valid_out && n < 20) begin
      cyc();
      n++;
    end
    chk("valid_seen", {31'b0, if_valid_out}, 32'h1);
    id_allowin_in = 1'b1;
    id_nextPC_in  = next_pc;
    cyc();
    id_allowin_in = 1'b0;
  endtask

  logic [31:0] exp_pcs[6]  = '{32'hBFC00000, 32'hBFC00100, 32'hBFC00102,
                               32'h80000180, 32'h80000300, 32'hFFFFFFFC};
  logic [31:0] exp_insts[6] = '{32'h24010001, 32'h3C010002, 32'h00000000,
                                32'h8C020004, 32'hAC030008, 32'h24420001};

  initial begin
    rst_n = 1'b0;
    id_allowin_in = 1'b0;
    id_nextPC_in = 32'h0;
    wb_ClrStpJmp_in = 1'b0;
    wb_cp0_res_in = 32'h0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    repeat (3) cyc();
    chk("reset_req", {31'b0, inst_req}, 32'h0);
    chk("reset_valid", {31'b0, if_valid_out}, 32'h0);
    rst_n = 1'b1;
    chk("reset_pc", if_PC_out, 32'hBFC00000);

    // First fetch: addr_ok one cycle late, data two cycles after that.
    wait_req(32'hBFC00000);
    cyc();
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    cyc();
    inst_data_ok = 1'b1;
    inst_rdata = 32'h24010001;
    cyc();
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    chk("s1_valid", {31'b0, if_valid_out}, 32'h1);
    chk("s1_inst", if_Instruct_out, 32'h24010001);
    chk("s1_npc", if_NPC_out, 32'hBFC00004);
    chk("s1_nnpc", if_NNPC_out, 32'hBFC00008);

    // Decode stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", {31'b0, if_valid_out}, 32'h1);
      chk("stall_req", {31'b0, inst_req}, 32'h0);
      chk("stall_inst", if_Instruct_out, 32'h24010001);
      chk("stall_pc", if_PC_out, 32'hBFC00000);
    end
    handoff(32'hBFC00100);
    wait_req(32'hBFC00100);
    quick_fetch(32'h3C010002);

    // Misaligned next PC.
    handoff(32'hBFC00102);
    chk("misalign_req", {31'b0, inst_req}, 32'h0);
    cyc();
    chk("adel_valid", {31'b0, if_valid_out}, 32'h1);
    chk("adel_exc", {31'b0, if_exception_out}, 32'h1);
    chk("adel_code", {27'b0, if_ExcCode_out}, 32'h4);
    chk("adel_vaddr", if_error_VAddr_out, 32'hBFC00102);
    chk("adel_inst", if_Instruct_out, 32'h0);

    // Flush while waiting for data; the stale word must be dropped.
    handoff(32'hBFC00200);
    wait_req(32'hBFC00200);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    wb_ClrStpJmp_in = 1'b1;
    wb_cp0_res_in = 32'h80000180;
    cyc();
    wb_ClrStpJmp_in = 1'b0;
    chk("discard_req", {31'b0, inst_req}, 32'h0);
    cyc();
    inst_data_ok = 1'b1;
    inst_rdata = 32'hDEADBEEF;
    cyc();
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    wait_req(32'h80000180);
    quick_fetch(32'h8C020004);
    chk("flush_pc", if_PC_out, 32'h80000180);
    chk("flush_valid", {31'b0, if_valid_out}, 32'h1);

    // Flush coinciding with addr_ok, then a second flush while discarding.
    handoff(32'h80000184);
    wait_req(32'h80000184);
    inst_addr_ok = 1'b1;
    wb_ClrStpJmp_in = 1'b1;
    wb_cp0_res_in = 32'h80000200;
    cyc();
    inst_addr_ok = 1'b0;
    wb_cp0_res_in = 32'h80000300;
    cyc();
    wb_ClrStpJmp_in = 1'b0;
    chk("reflush_pc", if_PC_out, 32'h80000300);
    chk("reflush_req", {31'b0, inst_req}, 32'h0);
    inst_data_ok = 1'b1;
    inst_rdata = 32'hDEADBEEF;
    cyc();
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    wait_req(32'h80000300);
    quick_fetch(32'hAC030008);

    // PC wrap.
    handoff(32'hFFFFFFFC);
    wait_req(32'hFFFFFFFC);
    chk("wrap_npc", if_NPC_out, 32'h00000000);
    chk("wrap_nnpc", if_NNPC_out, 32'h00000004);
    chk("wrap_fast", if_NPC_fast_wire, 32'h00000000);
    quick_fetch(32'h24420001);
    handoff(32'hBFC00000);
    repeat (2) cyc();

    chk("handoff_count", hand_pc.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < hand_pc.size()) begin
        chk("handoff_pc", hand_pc[i], exp_pcs[i]);
        chk("handoff_inst", hand_inst[i], exp_insts[i]);
      end
    end
    chk("stale_never_shown", {31'b0, saw_stale}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch pipeline stage directly upstream of the decode stage.
- Owns the fetch PC and drives a request/address-ok/data-ok instruction SRAM handshake.
- Holds one fetched instruction until decode accepts it, then presents it with PC, PC+4, PC+8, fetch exception info and the sequential next-PC hint.
- Takes the redirect PC chosen by decode and the writeback flush/redirect (exception/eret).

Parameters:
- RESET_PC, 32'hBFC00000: fetch PC after reset.
- ADEL_CODE, 5'h04: ExcCode reported for a misaligned fetch address.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- id_allowin_in  in  1  decode can accept an instruction this cycle.
- if_valid_out  out  1  stage holds a valid instruction for decode.
- id_nextPC_in  in  32  next fetch PC selected by decode (branch target or fast NPC).
- wb_ClrStpJmp_in  in  1  writeback flush plus redirect.
- wb_cp0_res_in  in  32  redirect target on flush.
- inst_req  out  1  SRAM request.
- inst_addr  out  32  SRAM request address.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  read data returned.
- inst_rdata  in  32  instruction word.
- if_PC_out  out  32  PC of the held instruction.
- if_NPC_out  out  32  PC+4.
- if_NNPC_out  out  32  PC+8.
- if_Instruct_out  out  32  held instruction word.
- if_NPC_fast_wire  out  32  combinational PC+4, the sequential-path hint for decode.
- if_exception_out  out  1  fetch exception flag.
- if_ExcCode_out  out  5  fetch ExcCode.
- if_error_VAddr_out  out  32  faulting address.

Behaviour:
- States: REQ, WAIT, VALID, DISCARD. Register pc (32b), inst_buf (32b), exc_r (1b).
- Reset (rst_n=0 at posedge):
  - state=REQ, pc=RESET_PC, inst_buf=0, exc_r=0.
  - During the reset cycle: inst_req=0, if_valid_out=0.
- REQ:
  - Aligned pc (pc[1:0]=0): inst_req=1, inst_addr=pc. On inst_addr_ok go to WAIT, otherwise hold the request.
  - Misaligned pc: inst_req=0, exc_r<=1, inst_buf<=0, go to VALID. No SRAM access is made.
- WAIT:
  - inst_req=0.
  - On inst_data_ok: inst_buf<=inst_rdata, exc_r<=0, go to VALID.
  - data_ok is never sampled in the same cycle as the addr_ok of the same request.
- VALID:
  - if_valid_out=1.
  - If id_allowin_in=1: pc<=id_nextPC_in, go to REQ. The next request issues the following cycle, so fetch latency is 2 cycles minimum.
  - Otherwise hold all outputs stable.
- DISCARD:
  - inst_req=0.
  - On inst_data_ok: drop the data and go to REQ.
- Flush (wb_ClrStpJmp_in=1) has highest priority in every state:
  - pc<=wb_cp0_res_in and if_valid_out=0 that cycle. No handoff to decode occurs.
  - If a request is outstanding (WAIT, DISCARD, or REQ with inst_addr_ok=1 this cycle), go to DISCARD. Otherwise go to REQ.
  - Repeated flush while in DISCARD: stay in DISCARD, pc updated.
  - Flush in WAIT coinciding with inst_data_ok: data dropped, go to REQ.
- Outputs:
  - if_PC_out=pc. if_NPC_out=pc+4 and if_NNPC_out=pc+8, both modulo 2^32.
  - if_NPC_fast_wire=pc+4.
  - if_Instruct_out=inst_buf when VALID, else 0.
  - if_exception_out=exc_r&&VALID.
  - if_ExcCode_out=ADEL_CODE when if_exception_out=1, else 0.
  - if_error_VAddr_out=pc when if_exception_out=1, else 0.
- Handoff:
  - An instruction transfers only when if_valid_out && id_allowin_in.
  - Exactly one handoff per fetched instruction. No duplicates, no drops except on flush.
- Wrap: pc=32'hFFFFFFFC gives NPC=0, NNPC=4.

Test Plan:
- Reset, addr_ok after 1 cycle, data_ok=32'h24010001 after 2 more, id_allowin=1 -> inst_addr=BFC00000; if_valid_out=1 with Instruct=24010001, NPC=BFC00004, NNPC=BFC00008; next request to id_nextPC_in.
- VALID with id_allowin=0 for 5 cycles -> all outputs stable, no inst_req; on allowin=1 with id_nextPC_in=BFC00100 -> next inst_addr=BFC00100.
- id_nextPC_in=BFC00102 -> no inst_req; if_valid_out=1, exception=1, ExcCode=04, error_VAddr=BFC00102, Instruct=0.
- Flush to 80000180 while in WAIT, then stale data_ok=32'hDEADBEEF -> DEADBEEF never presented; next inst_addr=80000180; first valid PC=80000180.
- Flush in the same cycle as inst_addr_ok, then data_ok -> data discarded, refetch at flush target; a second flush during DISCARD retargets pc with a single refetch.
- pc=FFFFFFFC fetched -> NPC=00000000, NNPC=00000004, fast_wire=00000000.
